// File: rtl/enemy_spawn_sched.sv
// Enemy spawn scheduler: keeps free enemy slots in a FIFO and issues one-hot spawn requests.
// Requests are gated by a wave-scaled cooldown and by a cap on how many enemies are alive.
module enemy_spawn_sched #(
  parameter int N_ENEMY        = 8,
  parameter int MAX_ALIVE      = 6,
  parameter int BASE_TICKS     = 10_000_000,
  parameter int MIN_TICKS      = 1_000_000,
  parameter int STEP_TICKS     = 1_000_000,
  parameter int KILLS_PER_WAVE = 10,
  parameter int WAVE_W         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         gameover,
  input  logic [N_ENEMY-1:0]           killed,
  input  logic [N_ENEMY-1:0]           spawned,
  output logic [N_ENEMY-1:0]           spawn,
  output logic                         active,
  output logic [WAVE_W-1:0]            wave,
  output logic [$clog2(N_ENEMY+1)-1:0] alive_cnt
);

  localparam int IDX_W = $clog2(N_ENEMY);
  localparam int CNT_W = $clog2(N_ENEMY + 1);
  localparam int KC_W  = $clog2(KILLS_PER_WAVE + N_ENEMY + 1);
  localparam int CD_W  = $clog2(BASE_TICKS + 1);
  localparam longint IV_MAX = longint'(BASE_TICKS) + (longint'(1) << WAVE_W) * longint'(STEP_TICKS);
  localparam int IV_W  = $clog2(IV_MAX + 1);

  typedef enum logic [1:0] {S_OVER, S_FILL, S_GAME} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   queue_q [N_ENEMY];
  logic [IDX_W-1:0]   queue_d [N_ENEMY];
  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d, fill_idx_q, fill_idx_d;
  logic [CNT_W-1:0]   count_q, count_d, alive_cnt_q, alive_cnt_d;
  logic [N_ENEMY-1:0] pending_q, pending_d;
  logic [WAVE_W-1:0]  wave_q, wave_d;
  logic [KC_W-1:0]    kill_cnt_q, kill_cnt_d;
  logic [CD_W-1:0]    cooldown_q, cooldown_d;

  logic [IDX_W-1:0]   head_idx, push_idx;
  logic               req, ack, push_en;
  logic [CNT_W-1:0]   kill_pop;
  logic [KC_W-1:0]    kill_sum;
  logic [N_ENEMY-1:0] pend_all;
  logic [IV_W-1:0]    wave_dec, interval;

  always_comb begin
    state_d     = state_q;
    queue_d     = queue_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_idx_d  = fill_idx_q;
    count_d     = count_q;
    alive_cnt_d = alive_cnt_q;
    pending_d   = pending_q;
    wave_d      = wave_q;
    kill_cnt_d  = kill_cnt_q;
    cooldown_d  = cooldown_q;
    kill_sum    = '0;

    head_idx = queue_q[head_q];
    req = (state_q == S_GAME) && (count_q != '0) && (cooldown_q == '0) &&
          (alive_cnt_q < CNT_W'(MAX_ALIVE));
    spawn = req ? (N_ENEMY'(1) << head_idx) : '0;
    ack   = req && spawned[head_idx];

    kill_pop = '0;
    for (int i = 0; i < N_ENEMY; i++) kill_pop = kill_pop + CNT_W'(killed[i]);

    // Descending scan so the lowest pending slot is the one that sticks.
    pend_all = pending_q | killed;
    push_en  = 1'b0;
    push_idx = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (pend_all[i]) begin
        push_en  = 1'b1;
        push_idx = IDX_W'(i);
      end
    end

    // Clamp before subtracting so a late wave never wraps to a huge cooldown.
    wave_dec = IV_W'(wave_q) * IV_W'(STEP_TICKS);
    if (wave_dec + IV_W'(MIN_TICKS) >= IV_W'(BASE_TICKS)) interval = IV_W'(MIN_TICKS);
    else                                                   interval = IV_W'(BASE_TICKS) - wave_dec;

    case (state_q)
      S_OVER: begin
        if (start) begin
          state_d     = S_FILL;
          head_d      = '0;
          tail_d      = '0;
          fill_idx_d  = '0;
          count_d     = '0;
          alive_cnt_d = '0;
          pending_d   = '0;
          wave_d      = '0;
          kill_cnt_d  = '0;
          cooldown_d  = '0;
        end
      end
      S_FILL: begin
        queue_d[tail_q] = fill_idx_q;
        tail_d          = tail_q + 1'b1;
        count_d         = count_q + 1'b1;
        fill_idx_d      = fill_idx_q + 1'b1;
        if (fill_idx_q == IDX_W'(N_ENEMY - 1)) state_d = S_GAME;
      end
      S_GAME: begin
        pending_d = pend_all;
        if (push_en) begin
          pending_d[push_idx] = 1'b0;
          queue_d[tail_q]     = push_idx;
          tail_d              = tail_q + 1'b1;
        end
        if (ack) head_d = head_q + 1'b1;
        count_d     = count_q + CNT_W'(push_en) - CNT_W'(ack);
        alive_cnt_d = alive_cnt_q + CNT_W'(ack) - kill_pop;

        kill_sum = kill_cnt_q + KC_W'(kill_pop);
        if (kill_sum >= KC_W'(KILLS_PER_WAVE)) begin
          kill_sum = kill_sum - KC_W'(KILLS_PER_WAVE);
          if (wave_q != {WAVE_W{1'b1}}) wave_d = wave_q + 1'b1;
        end
        kill_cnt_d = kill_sum;

        if (ack)                    cooldown_d = CD_W'(interval);
        else if (cooldown_q != '0)  cooldown_d = cooldown_q - 1'b1;

        if (gameover) state_d = S_OVER;
      end
      default: state_d = S_OVER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OVER;
      head_q      <= '0;
      tail_q      <= '0;
      fill_idx_q  <= '0;
      count_q     <= '0;
      alive_cnt_q <= '0;
      pending_q   <= '0;
      wave_q      <= '0;
      kill_cnt_q  <= '0;
      cooldown_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      fill_idx_q  <= fill_idx_d;
      count_q     <= count_d;
      alive_cnt_q <= alive_cnt_d;
      pending_q   <= pending_d;
      wave_q      <= wave_d;
      kill_cnt_q  <= kill_cnt_d;
      cooldown_q  <= cooldown_d;
    end
  end

  // Slot storage needs no reset: entries are only read between head and tail.
  always_ff @(posedge clk) begin
    queue_q <= queue_d;
  end

  assign active    = (state_q == S_GAME);
  assign wave      = wave_q;
  assign alive_cnt = alive_cnt_q;

endmodule
